// File: rtl/cordic_rotator_arbiter_if.sv
// Operand/result channel: valid/ready handshake carrying an (x, y, angle) triple.
interface cordic_rotator_arbiter_if #(
  parameter int unsigned WIDTH = 16
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] a;

  modport master (output valid, output x, output y, output a, input ready);
  modport slave  (input valid, input x, input y, input a, output ready);
endinterface

// File: rtl/cordic_rotator_arbiter.sv
// Shares one non-stallable pipelined CORDIC rotator between two requesters.
// Round-robin issue is gated by per-requester credits so that every result
// leaving the rotator always has a free slot in its response FIFO.
module cordic_rotator_arbiter #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned ROT_LATENCY = 16,
  parameter int unsigned RSP_DEPTH   = 4
) (
  input  logic                     clock,
  input  logic                     rstn,
  cordic_rotator_arbiter_if.slave  req0,
  cordic_rotator_arbiter_if.slave  req1,
  cordic_rotator_arbiter_if.master rsp0,
  cordic_rotator_arbiter_if.master rsp1,
  output logic [WIDTH-1:0]         rot_in_x,
  output logic [WIDTH-1:0]         rot_in_y,
  output logic [WIDTH-1:0]         rot_in_a,
  input  logic [WIDTH-1:0]         rot_out_x,
  input  logic [WIDTH-1:0]         rot_out_y,
  input  logic [WIDTH-1:0]         rot_out_a,
  output logic                     busy
);

  localparam int unsigned CW = $clog2(RSP_DEPTH + 1);
  localparam int unsigned PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned TL = ROT_LATENCY;
  localparam int unsigned DW = 3 * WIDTH;

  logic [1:0]    req_valid;
  logic [1:0]    rsp_ready;
  logic [1:0]    elig;
  logic [1:0]    grant;
  logic [1:0]    wr;
  logic [1:0]    pop;
  logic [1:0]    nonempty;
  logic [DW-1:0] req_data [2];
  logic [CW-1:0] credit [2];
  logic [CW-1:0] count [2];
  logic [PW-1:0] rd_ptr [2];
  logic [PW-1:0] wr_ptr [2];
  logic [DW-1:0] mem [2][RSP_DEPTH];
  logic          last_grant;
  logic [TL:0]   tag_valid;
  logic [TL:0]   tag_id;
  logic [DW-1:0] rot_in;

  // Circular pointer advance for a FIFO of RSP_DEPTH entries.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(RSP_DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  assign req_valid   = {req1.valid, req0.valid};
  assign rsp_ready   = {rsp1.ready, rsp0.ready};
  assign req_data[0] = {req0.x, req0.y, req0.a};
  assign req_data[1] = {req1.x, req1.y, req1.a};

  // Eligibility, round-robin grant, FIFO write/pop strobes.
  always_comb begin
    elig     = '0;
    grant    = '0;
    wr       = '0;
    pop      = '0;
    nonempty = '0;
    for (int n = 0; n < 2; n++) begin
      nonempty[n] = (count[n] != '0);
      elig[n]     = rstn && req_valid[n] && (credit[n] != '0);
      wr[n]       = tag_valid[TL] && (tag_id[TL] == 1'(n));
      pop[n]      = nonempty[n] && rsp_ready[n];
    end
    if (elig[0] && (!elig[1] || last_grant)) begin
      grant[0] = 1'b1;
    end else if (elig[1]) begin
      grant[1] = 1'b1;
    end
  end

  // Round-robin pointer and registered rotator operands.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      last_grant <= 1'b1;
      rot_in     <= '0;
    end else if (|grant) begin
      last_grant <= grant[1];
      rot_in     <= grant[1] ? req_data[1] : req_data[0];
    end
  end

  // Tag pipe tracking which requester owns each op inside the rotator.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      tag_valid <= '0;
      tag_id    <= '0;
    end else begin
      tag_valid[0] <= |grant;
      tag_id[0]    <= grant[1];
      for (int i = 1; i <= int'(TL); i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_id[i]    <= tag_id[i-1];
      end
    end
  end

  // Credit counters and response FIFO occupancy/pointers.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      for (int n = 0; n < 2; n++) begin
        credit[n] <= CW'(RSP_DEPTH);
        count[n]  <= '0;
        rd_ptr[n] <= '0;
        wr_ptr[n] <= '0;
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (grant[n] && !pop[n]) begin
          credit[n] <= credit[n] - CW'(1);
        end else if (pop[n] && !grant[n]) begin
          credit[n] <= credit[n] + CW'(1);
        end
        if (wr[n] && !pop[n]) begin
          count[n] <= count[n] + CW'(1);
        end else if (pop[n] && !wr[n]) begin
          count[n] <= count[n] - CW'(1);
        end
        if (wr[n]) wr_ptr[n] <= ptr_inc(wr_ptr[n]);
        if (pop[n]) rd_ptr[n] <= ptr_inc(rd_ptr[n]);
      end
    end
  end

  // Response storage; contents are don't-care until written.
  always_ff @(posedge clock) begin
    for (int n = 0; n < 2; n++) begin
      if (wr[n]) mem[n][wr_ptr[n]] <= {rot_out_x, rot_out_y, rot_out_a};
    end
  end

  assign rot_in_x = rot_in[DW-1 -: WIDTH];
  assign rot_in_y = rot_in[DW-WIDTH-1 -: WIDTH];
  assign rot_in_a = rot_in[WIDTH-1:0];

  assign req0.ready = grant[0];
  assign req1.ready = grant[1];

  assign rsp0.valid = nonempty[0];
  assign rsp0.x     = mem[0][rd_ptr[0]][DW-1 -: WIDTH];
  assign rsp0.y     = mem[0][rd_ptr[0]][DW-WIDTH-1 -: WIDTH];
  assign rsp0.a     = mem[0][rd_ptr[0]][WIDTH-1:0];
  assign rsp1.valid = nonempty[1];
  assign rsp1.x     = mem[1][rd_ptr[1]][DW-1 -: WIDTH];
  assign rsp1.y     = mem[1][rd_ptr[1]][DW-WIDTH-1 -: WIDTH];
  assign rsp1.a     = mem[1][rd_ptr[1]][WIDTH-1:0];

  assign busy = (|tag_valid) || (|nonempty);

  // Credits guarantee a slot; a capture into a full FIFO means the accounting broke.
  a_no_overflow: assert property (@(posedge clock) disable iff (!rstn)
    !(wr[0] && (count[0] == CW'(RSP_DEPTH))) && !(wr[1] && (count[1] == CW'(RSP_DEPTH))));

endmodule

// File: tb/tb_cordic_rotator_arbiter.sv
// Randomized bench for cordic_rotator_arbiter against a queue-based reference
// model; the rotator is stood in for by a pure ROT_LATENCY-stage delay line.
module tb_cordic_rotator_arbiter;

  localparam int unsigned WIDTH       = 16;
  localparam int unsigned ROT_LATENCY = 16;
  localparam int unsigned RSP_DEPTH   = 4;
  localparam int          RSP_LAT     = int'(ROT_LATENCY) + 1;

  logic             clock = 1'b0;
  logic             rstn;
  logic [WIDTH-1:0] rot_in_x, rot_in_y, rot_in_a;
  logic [WIDTH-1:0] rot_out_x, rot_out_y, rot_out_a;
  logic             busy;

  cordic_rotator_arbiter_if #(.WIDTH(WIDTH)) req0_if ();
  cordic_rotator_arbiter_if #(.WIDTH(WIDTH)) req1_if ();
  cordic_rotator_arbiter_if #(.WIDTH(WIDTH)) rsp0_if ();
  cordic_rotator_arbiter_if #(.WIDTH(WIDTH)) rsp1_if ();

  cordic_rotator_arbiter #(
    .WIDTH(WIDTH), .ROT_LATENCY(ROT_LATENCY), .RSP_DEPTH(RSP_DEPTH)
  ) dut (
    .clock(clock), .rstn(rstn),
    .req0(req0_if), .req1(req1_if), .rsp0(rsp0_if), .rsp1(rsp1_if),
    .rot_in_x(rot_in_x), .rot_in_y(rot_in_y), .rot_in_a(rot_in_a),
    .rot_out_x(rot_out_x), .rot_out_y(rot_out_y), .rot_out_a(rot_out_a),
    .busy(busy)
  );

  always #5 clock = ~clock;

  // Rotator stand-in: pure delay, result valid ROT_LATENCY edges after rot_in changes.
  logic [47:0] rot_pipe [ROT_LATENCY];
  always_ff @(posedge clock) begin
    rot_pipe[0] <= {rot_in_x, rot_in_y, rot_in_a};
    for (int i = 1; i < int'(ROT_LATENCY); i++) rot_pipe[i] <= rot_pipe[i-1];
  end
  assign {rot_out_x, rot_out_y, rot_out_a} = rot_pipe[ROT_LATENCY-1];

  // Reference model state.
  typedef struct {
    int          due;
    int          req;
    logic [47:0] data;
  } op_t;

  op_t         inflight [$];
  logic [47:0] m_fifo0 [$];
  logic [47:0] m_fifo1 [$];
  int          credit [2];
  int          last_g;
  logic [47:0] m_rot;
  int          m_edge;
  int          acc0_seen;
  int          acc1_seen;
  int          n_total;
  int          n_bad;

  task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] rand_word();
    case ($urandom_range(0, 3))
      0:       return 16'hFFFF;
      1:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic void model_reset();
    inflight.delete();
    m_fifo0.delete();
    m_fifo1.delete();
    credit[0] = int'(RSP_DEPTH);
    credit[1] = int'(RSP_DEPTH);
    last_g    = 1;
    m_rot     = '0;
  endfunction

  // Which requester the spec's round-robin rule grants now (-1 = none).
  function automatic int model_grant();
    bit e0;
    bit e1;
    e0 = req0_if.valid && (credit[0] > 0);
    e1 = req1_if.valid && (credit[1] > 0);
    if (e0 && e1) return (last_g == 0) ? 1 : 0;
    if (e0) return 0;
    if (e1) return 1;
    return -1;
  endfunction

  function automatic void model_edge(input int g, input bit p0, input bit p1, input logic [47:0] d);
    op_t o;
    m_edge++;
    if (p0) begin void'(m_fifo0.pop_front()); credit[0]++; end
    if (p1) begin void'(m_fifo1.pop_front()); credit[1]++; end
    while (inflight.size() > 0 && inflight[0].due == m_edge) begin
      o = inflight.pop_front();
      if (o.req == 0) m_fifo0.push_back(o.data);
      else            m_fifo1.push_back(o.data);
    end
    if (g >= 0) begin
      credit[g]--;
      last_g = g;
      m_rot  = d;
      o.due  = m_edge + RSP_LAT;
      o.req  = g;
      o.data = d;
      inflight.push_back(o);
    end
  endfunction

  task automatic check_outputs();
    check_eq("rsp0_valid", 48'(rsp0_if.valid), 48'(m_fifo0.size() > 0));
    if (m_fifo0.size() > 0) check_eq("rsp0_data", {rsp0_if.x, rsp0_if.y, rsp0_if.a}, m_fifo0[0]);
    check_eq("rsp1_valid", 48'(rsp1_if.valid), 48'(m_fifo1.size() > 0));
    if (m_fifo1.size() > 0) check_eq("rsp1_data", {rsp1_if.x, rsp1_if.y, rsp1_if.a}, m_fifo1[0]);
    check_eq("rot_in", {rot_in_x, rot_in_y, rot_in_a}, m_rot);
    check_eq("busy", 48'(busy),
             48'(inflight.size() > 0 || m_fifo0.size() > 0 || m_fifo1.size() > 0));
  endtask

  // One clock: inputs were driven just before the call (edge + 1).
  task automatic do_cycle();
    int          g;
    bit          p0;
    bit          p1;
    logic [47:0] d;
    #1;
    g = model_grant();
    check_eq("ready0", 48'(req0_if.ready), 48'(g == 0));
    check_eq("ready1", 48'(req1_if.ready), 48'(g == 1));
    if (req0_if.valid && req0_if.ready) acc0_seen++;
    if (req1_if.valid && req1_if.ready) acc1_seen++;
    p0 = (m_fifo0.size() > 0) && rsp0_if.ready;
    p1 = (m_fifo1.size() > 0) && rsp1_if.ready;
    d  = (g == 1) ? {req1_if.x, req1_if.y, req1_if.a} : {req0_if.x, req0_if.y, req0_if.a};
    @(posedge clock);
    model_edge(g, p0, p1, d);
    #1;
    check_outputs();
  endtask

  task automatic drive(input bit v0, input bit v1, input bit r0, input bit r1);
    req0_if.valid = v0;
    req1_if.valid = v1;
    rsp0_if.ready = r0;
    rsp1_if.ready = r1;
    req0_if.x = rand_word(); req0_if.y = rand_word(); req0_if.a = rand_word();
    req1_if.x = rand_word(); req1_if.y = rand_word(); req1_if.a = rand_word();
  endtask

  task automatic run(input int cycles, input bit v0, input bit v1, input bit r0, input bit r1);
    for (int i = 0; i < cycles; i++) begin
      drive(v0, v1, r0, r1);
      do_cycle();
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    while (busy && k < 100) begin
      do_cycle();
      k++;
    end
    check_eq("drain_idle", 48'(busy), 48'(0));
  endtask

  // Asynchronous reset asserted mid-cycle, then released at edge + 1.
  task automatic reset_mid();
    #2 rstn = 1'b0;
    #1;
    check_eq("rst_ready0", 48'(req0_if.ready), 48'(0));
    check_eq("rst_ready1", 48'(req1_if.ready), 48'(0));
    check_eq("rst_rsp0_valid", 48'(rsp0_if.valid), 48'(0));
    check_eq("rst_rsp1_valid", 48'(rsp1_if.valid), 48'(0));
    check_eq("rst_rot_in", {rot_in_x, rot_in_y, rot_in_a}, 48'(0));
    check_eq("rst_busy", 48'(busy), 48'(0));
    model_reset();
    repeat (2) @(posedge clock);
    #1 rstn = 1'b1;
    check_outputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_total = 0;
    n_bad   = 0;
    m_edge  = 0;
    acc0_seen = 0;
    acc1_seen = 0;
    model_reset();
    rstn = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0);

    // Reset values while requests are presented.
    @(posedge clock);
    #1 reset_mid();

    // Both requesters continuously valid: alternate starting with req0, credit-limited.
    acc0_seen = 0; acc1_seen = 0;
    run(8, 1'b1, 1'b1, 1'b1, 1'b1);
    check_eq("alt_acc0", 48'(acc0_seen), 48'(4));
    check_eq("alt_acc1", 48'(acc1_seen), 48'(4));
    run(40, 1'b1, 1'b1, 1'b1, 1'b1);
    drain();

    // Single op on req0 with fixed operands.
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    req0_if.x = 16'h00FF; req0_if.y = 16'h00AA; req0_if.a = 16'h0001;
    do_cycle();
    check_eq("single_rot_in", {rot_in_x, rot_in_y, rot_in_a}, 48'h00FF_00AA_0001);
    run(RSP_LAT - 1, 1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("single_early", 48'(rsp0_if.valid), 48'(0));
    run(1, 1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("single_rsp_valid", 48'(rsp0_if.valid), 48'(1));
    check_eq("single_rsp_data", {rsp0_if.x, rsp0_if.y, rsp0_if.a}, 48'h00FF_00AA_0001);
    check_eq("single_rsp1_quiet", 48'(rsp1_if.valid), 48'(0));
    drain();

    // req1 with all-ones angle: bit-exact and routed to rsp1 only.
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    req1_if.x = 16'h00FF; req1_if.y = 16'h00AA; req1_if.a = 16'hFFFF;
    do_cycle();
    check_eq("ones_rot_a", 48'(rot_in_a), 48'h0000_0000_FFFF);
    run(RSP_LAT, 1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("ones_rsp1_valid", 48'(rsp1_if.valid), 48'(1));
    check_eq("ones_rsp1_data", {rsp1_if.x, rsp1_if.y, rsp1_if.a}, 48'h00FF_00AA_FFFF);
    check_eq("ones_rsp0_quiet", 48'(rsp0_if.valid), 48'(0));
    drain();

    // Random traffic with random consumer back-pressure.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 4) != 0));
      do_cycle();
    end
    drain();

    // req0 consumer stalled: exactly RSP_DEPTH accepts, then one pop frees one credit.
    acc0_seen = 0;
    run(30, 1'b1, 1'b1, 1'b0, 1'b1);
    check_eq("stall_acc0", 48'(acc0_seen), 48'(RSP_DEPTH));
    run(1, 1'b1, 1'b1, 1'b1, 1'b1);
    check_eq("pop_no_bypass", 48'(acc0_seen), 48'(RSP_DEPTH));
    run(3, 1'b1, 1'b1, 1'b0, 1'b1);
    check_eq("pop_credit_back", 48'(acc0_seen), 48'(RSP_DEPTH + 1));
    drain();

    // Reset with two results queued and three ops in flight.
    run(2, 1'b1, 1'b0, 1'b0, 1'b0);
    run(RSP_LAT + 1, 1'b0, 1'b0, 1'b0, 1'b0);
    run(3, 1'b0, 1'b1, 1'b0, 1'b0);
    run(2, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("pre_rst_q0", 48'(rsp0_if.valid), 48'(1));
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    reset_mid();
    run(RSP_LAT + 3, 1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("post_rst_quiet", 48'(rsp0_if.valid || rsp1_if.valid), 48'(0));

    // Random traffic again after a mid-operation reset.
    for (int i = 0; i < 150; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      do_cycle();
    end
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
